// File: rtl/gate_barrier_ctrl_pkg.sv
// Shared types, default parameter values and counter sizing for the
// entry-gate barrier controller.
package gate_pkg;

   typedef enum logic [2:0] {
      ST_CLOSED    = 3'd0,
      ST_OPENING   = 3'd1,
      ST_OPEN_WAIT = 3'd2,
      ST_CAR_IN    = 3'd3,
      ST_CLOSING   = 3'd4,
      ST_FAULT     = 3'd5
   } gate_state_e;

   localparam int TRAVEL_MAX_DEF   = 200;
   localparam int PASS_TIMEOUT_DEF = 1000;
   localparam int CLEAR_HOLD_DEF   = 8;

   // Width of the shared state counter: wide enough to hold the largest limit.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/gate_barrier_ctrl_if.sv
// Handshake and sensor/actuator bundle between the barrier controller and
// its surroundings (access FSM upstream, barrier hardware downstream).
interface gate_barrier_ctrl_if;
   logic access_granted;
   logic loop_sensor;
   logic up_limit;
   logic down_limit;
   logic motor_up;
   logic motor_down;
   logic busy;
   logic car_entered;
   logic car_abort;
   logic gate_fault;

   // Environment side: drives grant and sensors, observes the controller.
   modport master (
      output access_granted, loop_sensor, up_limit, down_limit,
      input  motor_up, motor_down, busy, car_entered, car_abort, gate_fault
   );

   // Controller side.
   modport slave (
      input  access_granted, loop_sensor, up_limit, down_limit,
      output motor_up, motor_down, busy, car_entered, car_abort, gate_fault
   );
endinterface

// File: rtl/gate_barrier_ctrl_sync.sv
// Parameterized-width two-flop synchronizer, async active-low reset to 0.
module gate_sync #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;

   // Two back-to-back flops; only sync_q is safe to use downstream.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/gate_barrier_ctrl.sv
// Entry-gate barrier controller: raises the barrier on a grant, waits for the
// car to cross the loop, closes with obstruction reversal, and reports
// car_entered / car_abort back to the spot counter.
module gate_barrier_ctrl
   import gate_pkg::*;
#(
   parameter int TRAVEL_MAX   = TRAVEL_MAX_DEF,
   parameter int PASS_TIMEOUT = PASS_TIMEOUT_DEF,
   parameter int CLEAR_HOLD   = CLEAR_HOLD_DEF
) (
   input logic                clk,
   input logic                reset_n,
   gate_barrier_ctrl_if.slave bus
);

   localparam int CW = cnt_width(TRAVEL_MAX, PASS_TIMEOUT, CLEAR_HOLD);
   typedef logic [CW-1:0] cnt_t;

   localparam cnt_t TRAVEL_C  = cnt_t'(TRAVEL_MAX);
   localparam cnt_t PASS_C    = cnt_t'(PASS_TIMEOUT);
   localparam cnt_t CLEAR_C   = cnt_t'(CLEAR_HOLD);
   localparam cnt_t CNT_MAX   = {CW{1'b1}};

   // ---------------------------------------------------------------- sync
   logic [2:0] sens_raw;
   logic [2:0] sens_s;
   logic       loop_s, up_s, dn_s;

   assign sens_raw = {bus.loop_sensor, bus.up_limit, bus.down_limit};

   gate_sync #(.W(3)) u_sync (
      .clk   (clk),
      .rst_n (reset_n),
      .d     (sens_raw),
      .q     (sens_s)
   );

   assign loop_s = sens_s[2];
   assign up_s   = sens_s[1];
   assign dn_s   = sens_s[0];

   // ---------------------------------------------------------------- state
   gate_state_e state_q, state_d;
   cnt_t        cnt_q, cnt_d, cnt_inc;
   logic        passed_q, passed_d;
   logic        motor_up_q, motor_up_d;
   logic        motor_down_q, motor_down_d;
   logic        busy_q, busy_d;
   logic        entered_q, entered_d;
   logic        abort_q, abort_d;
   logic        fault_q, fault_d;

   // Next state, counter, passed flag and outcome pulses.
   always_comb begin
      state_d   = state_q;
      cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      cnt_d     = cnt_inc;
      passed_d  = passed_q;
      entered_d = 1'b0;
      abort_d   = 1'b0;

      unique case (state_q)
         ST_CLOSED: begin
            if (bus.access_granted) state_d = ST_OPENING;
         end
         ST_OPENING: begin
            if (up_s)                   state_d = ST_OPEN_WAIT;
            else if (cnt_q == TRAVEL_C) state_d = ST_FAULT;
         end
         ST_OPEN_WAIT: begin
            if (loop_s) begin
               state_d = ST_CAR_IN;
            end else if (cnt_q == PASS_C) begin
               state_d = ST_CLOSING;
               abort_d = !passed_q;
               // the abort consumes this grant's single report
               passed_d = 1'b1;
            end
         end
         ST_CAR_IN: begin
            // counter measures how long the loop has been continuously clear
            if (cnt_q == CLEAR_C) begin
               state_d   = ST_CLOSING;
               entered_d = !passed_q;
               passed_d  = 1'b1;
            end else if (loop_s) begin
               cnt_d = '0;
            end
         end
         ST_CLOSING: begin
            // obstruction reversal wins over reaching the down limit
            if (loop_s) begin
               state_d = ST_OPENING;
            end else if (dn_s) begin
               state_d  = ST_CLOSED;
               passed_d = 1'b0;
            end else if (cnt_q == TRAVEL_C) begin
               state_d = ST_FAULT;
            end
         end
         ST_FAULT: begin
            state_d = ST_FAULT;
         end
         default: state_d = ST_FAULT;
      endcase

      // Both limits at once means a broken sensor or mechanism: stop everything.
      if (up_s && dn_s) begin
         state_d   = ST_FAULT;
         entered_d = 1'b0;
         abort_d   = 1'b0;
         passed_d  = passed_q;
      end

      if (state_d != state_q) cnt_d = '0;
   end

   // Output decode from the next state so outputs line up with the state flop.
   always_comb begin
      motor_up_d   = (state_d == ST_OPENING);
      motor_down_d = (state_d == ST_CLOSING);
      busy_d       = (state_d != ST_CLOSED);
      fault_d      = (state_d == ST_FAULT);
   end

   // State, counter, flag and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_CLOSED;
         cnt_q        <= '0;
         passed_q     <= 1'b0;
         motor_up_q   <= 1'b0;
         motor_down_q <= 1'b0;
         busy_q       <= 1'b0;
         entered_q    <= 1'b0;
         abort_q      <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         passed_q     <= passed_d;
         motor_up_q   <= motor_up_d;
         motor_down_q <= motor_down_d;
         busy_q       <= busy_d;
         entered_q    <= entered_d;
         abort_q      <= abort_d;
         fault_q      <= fault_d;
      end
   end

   assign bus.motor_up    = motor_up_q;
   assign bus.motor_down  = motor_down_q;
   assign bus.busy        = busy_q;
   assign bus.car_entered = entered_q;
   assign bus.car_abort   = abort_q;
   assign bus.gate_fault  = fault_q;

endmodule

// File: tb/tb_gate_barrier_ctrl.sv
// Directed bench for gate_barrier_ctrl with small timeouts.
module tb_gate_barrier_ctrl;
   logic clk;
   logic reset_n;
   int   n_vec;
   int   n_bad;
   int   n_ent;
   int   n_abt;
   int   ent0;
   int   abt0;

   gate_barrier_ctrl_if bus ();

   gate_barrier_ctrl #(
      .TRAVEL_MAX   (20),
      .PASS_TIMEOUT (50),
      .CLEAR_HOLD   (4)
   ) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // running totals of outcome pulses
   initial begin
      n_ent = 0;
      n_abt = 0;
   end
   always @(negedge clk) begin
      if (bus.car_entered) n_ent++;
      if (bus.car_abort)   n_abt++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      bus.access_granted = 1'b0;
      bus.loop_sensor    = 1'b0;
      bus.up_limit       = 1'b0;
      bus.down_limit     = 1'b1;
      cyc(2);
      reset_n = 1'b1;
      cyc(3);
   endtask

   // grant pulse; barrier leaves the down limit as it starts to rise
   task automatic grant();
      bus.access_granted = 1'b1;
      bus.down_limit     = 1'b0;
      cyc(1);
      bus.access_granted = 1'b0;
   endtask

   initial begin
      n_vec = 0;
      n_bad = 0;
      @(negedge clk);
      do_reset();

      // reset state
      chk("rst_motor_up",   32'(bus.motor_up),    0);
      chk("rst_motor_down", 32'(bus.motor_down),  0);
      chk("rst_busy",       32'(bus.busy),        0);
      chk("rst_fault",      32'(bus.gate_fault),  0);
      chk("rst_entered",    32'(bus.car_entered), 0);
      chk("rst_abort",      32'(bus.car_abort),   0);

      // normal entry
      ent0 = n_ent; abt0 = n_abt;
      grant();
      chk("ne_motor_up_on", 32'(bus.motor_up), 1);
      chk("ne_busy_on",     32'(bus.busy),     1);
      cyc(9);
      bus.up_limit = 1'b1;
      cyc(2);
      chk("ne_motor_up_hold", 32'(bus.motor_up), 1);
      cyc(1);
      chk("ne_motor_up_off",  32'(bus.motor_up), 0);
      bus.loop_sensor = 1'b1;
      cyc(15);
      bus.loop_sensor = 1'b0;
      cyc(6);
      chk("ne_down_before", 32'(bus.motor_down), 0);
      cyc(1);
      chk("ne_down_on",     32'(bus.motor_down),  1);
      chk("ne_entered",     32'(bus.car_entered), 1);
      chk("ne_no_up",       32'(bus.motor_up),    0);
      cyc(1);
      chk("ne_entered_1cyc", 32'(bus.car_entered), 0);
      bus.up_limit = 1'b0;
      cyc(2);
      bus.down_limit = 1'b1;
      cyc(2);
      chk("ne_busy_closing", 32'(bus.busy), 1);
      cyc(1);
      chk("ne_busy_closed",  32'(bus.busy),       0);
      chk("ne_down_off",     32'(bus.motor_down), 0);
      chk("ne_ent_count",    32'(n_ent - ent0), 1);
      chk("ne_abt_count",    32'(n_abt - abt0), 0);

      // no car: grant expires
      ent0 = n_ent; abt0 = n_abt;
      grant();
      cyc(4);
      bus.up_limit = 1'b1;
      cyc(53);
      chk("nc_down_before", 32'(bus.motor_down), 0);
      chk("nc_abort_before", 32'(bus.car_abort), 0);
      cyc(1);
      chk("nc_down_on", 32'(bus.motor_down), 1);
      chk("nc_abort",   32'(bus.car_abort),  1);
      cyc(1);
      chk("nc_abort_1cyc", 32'(bus.car_abort), 0);
      bus.up_limit = 1'b0;
      cyc(2);
      bus.down_limit = 1'b1;
      cyc(3);
      chk("nc_busy_closed", 32'(bus.busy), 0);
      chk("nc_ent_count", 32'(n_ent - ent0), 0);
      chk("nc_abt_count", 32'(n_abt - abt0), 1);

      // obstruction during closing, then reclose with no second report
      ent0 = n_ent; abt0 = n_abt;
      grant();
      cyc(2);
      bus.up_limit = 1'b1;
      cyc(3);
      bus.loop_sensor = 1'b1;
      cyc(5);
      bus.loop_sensor = 1'b0;
      cyc(7);
      chk("ob_down_on", 32'(bus.motor_down), 1);
      bus.up_limit = 1'b0;
      cyc(2);
      bus.loop_sensor = 1'b1;
      cyc(3);
      chk("ob_rev_down_off", 32'(bus.motor_down), 0);
      chk("ob_rev_up_on",    32'(bus.motor_up),   1);
      bus.loop_sensor = 1'b0;
      bus.up_limit    = 1'b1;
      cyc(53);
      chk("ob_wait_before", 32'(bus.motor_down), 0);
      cyc(1);
      chk("ob_reclose",  32'(bus.motor_down), 1);
      chk("ob_no_abort", 32'(bus.car_abort),  0);
      bus.up_limit = 1'b0;
      cyc(1);
      bus.down_limit = 1'b1;
      cyc(3);
      chk("ob_busy_closed", 32'(bus.busy), 0);
      chk("ob_ent_count", 32'(n_ent - ent0), 1);
      chk("ob_abt_count", 32'(n_abt - abt0), 0);

      // second grant while CAR_IN has no effect
      ent0 = n_ent; abt0 = n_abt;
      grant();
      cyc(2);
      bus.up_limit = 1'b1;
      cyc(3);
      bus.loop_sensor = 1'b1;
      cyc(3);
      bus.access_granted = 1'b1;
      cyc(1);
      bus.access_granted = 1'b0;
      cyc(2);
      chk("gb_motor_up", 32'(bus.motor_up), 0);
      chk("gb_busy",     32'(bus.busy),     1);
      bus.loop_sensor = 1'b0;
      cyc(7);
      chk("gb_down_on", 32'(bus.motor_down), 1);
      bus.up_limit = 1'b0;
      cyc(1);
      bus.down_limit = 1'b1;
      cyc(3);
      chk("gb_busy_closed", 32'(bus.busy), 0);
      chk("gb_ent_count", 32'(n_ent - ent0), 1);

      // both limits while OPEN_WAIT
      grant();
      cyc(2);
      bus.up_limit = 1'b1;
      cyc(3);
      chk("bl_open_wait", 32'(bus.motor_up), 0);
      bus.down_limit = 1'b1;
      cyc(2);
      chk("bl_fault_before", 32'(bus.gate_fault), 0);
      cyc(1);
      chk("bl_fault", 32'(bus.gate_fault), 1);
      chk("bl_busy",  32'(bus.busy),       1);
      chk("bl_motors", 32'({bus.motor_up, bus.motor_down}), 0);
      do_reset();
      chk("bl_fault_cleared", 32'(bus.gate_fault), 0);

      // motor stall in OPENING
      grant();
      cyc(20);
      chk("st_fault_before", 32'(bus.gate_fault), 0);
      chk("st_up_before",    32'(bus.motor_up),   1);
      cyc(1);
      chk("st_fault",  32'(bus.gate_fault), 1);
      chk("st_motors", 32'({bus.motor_up, bus.motor_down}), 0);
      grant();
      cyc(3);
      chk("st_grant_ignored", 32'(bus.motor_up),   0);
      chk("st_fault_sticky",  32'(bus.gate_fault), 1);
      do_reset();
      chk("st_fault_reset", 32'(bus.gate_fault), 0);

      // reset mid-OPENING
      ent0 = n_ent; abt0 = n_abt;
      grant();
      cyc(2);
      chk("rm_up_before", 32'(bus.motor_up), 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("rm_up",    32'(bus.motor_up),   0);
      chk("rm_busy",  32'(bus.busy),       0);
      chk("rm_fault", 32'(bus.gate_fault), 0);
      chk("rm_pulses", 32'({bus.car_entered, bus.car_abort}), 0);
      bus.down_limit = 1'b1;
      cyc(2);
      reset_n = 1'b1;
      cyc(3);
      chk("rm_busy_after", 32'(bus.busy), 0);
      chk("rm_no_pulse", 32'((n_ent - ent0) + (n_abt - abt0)), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   // global bound so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/gate_barrier_ctrl.md
# gate_barrier_ctrl

Entry-gate barrier controller sitting directly downstream of the parking access/spot-count FSM. It consumes that block's one-cycle `access_granted` pulse, drives the barrier motor up, waits for the car to cross the induction loop, then closes the barrier with obstruction reversal. It reports the outcome back upstream: `car_entered` confirms the spot is consumed, and `car_abort` lets the spot counter restore a granted-but-unused spot.

## Interface
- `TRAVEL_MAX`, default 200: maximum cycles of motor travel before a limit switch must be reached.
- `PASS_TIMEOUT`, default 1000: cycles the barrier stays open waiting for a car before auto-close.
- `CLEAR_HOLD`, default 8: consecutive cycles the loop must read clear before closing.
- `clk`  in  1  system clock. One clock domain; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `access_granted`  in  1  one-cycle grant pulse from the access FSM. Same clock domain; not synchronized.
- `loop_sensor`  in  1  vehicle present under barrier. Asynchronous input.
- `up_limit`  in  1  barrier fully raised. Asynchronous input.
- `down_limit`  in  1  barrier fully lowered. Asynchronous input.
- `motor_up`  out  1  raise barrier. Registered.
- `motor_down`  out  1  lower barrier. Registered.
- `busy`  out  1  high in every state except CLOSED.
- `car_entered`  out  1  one-cycle pulse when a car has fully passed.
- `car_abort`  out  1  one-cycle pulse when a grant expired unused.
- `gate_fault`  out  1  sticky fault indicator.

## Operation
- **Input sync.** `loop_sensor`, `up_limit` and `down_limit` each pass through a 2-flop synchronizer, giving `loop_s`, `up_s` and `dn_s`. The FSM uses only the synchronized versions.
- **Reset values.** State CLOSED, counter 0, `passed` flag 0, all outputs 0.
- **Counter.** One shared up-counter, cleared on every state change. Width is `$clog2(max(TRAVEL_MAX, PASS_TIMEOUT, CLEAR_HOLD)+1)`. It saturates and never wraps.
- **CLOSED:** motors off. `access_granted` moves to OPENING. Grants arriving in any other state are ignored; `busy` tells upstream to hold off.
- **OPENING:** `motor_up` = 1.
  - `up_s` moves to OPEN_WAIT.
  - Counter == `TRAVEL_MAX` moves to FAULT.
- **OPEN_WAIT:** motors off.
  - `loop_s` moves to CAR_IN.
  - Counter == `PASS_TIMEOUT` moves to CLOSING. It also pulses `car_abort`, but only if `passed` = 0.
- **CAR_IN:** motors off.
  - The counter counts consecutive `loop_s` = 0 cycles; `loop_s` = 1 clears it.
  - Counter == `CLEAR_HOLD` moves to CLOSING. It also pulses `car_entered` if `passed` = 0, and sets `passed` = 1.
- **CLOSING:** `motor_down` = 1.
  - `dn_s` moves to CLOSED and clears `passed`.
  - `loop_s` (obstruction) moves to OPENING. This reversal has priority over `dn_s` in the same cycle.
  - Counter == `TRAVEL_MAX` moves to FAULT.
- **FAULT:** motors off, `gate_fault` = 1. Exit is only via `reset_n`.
- **Both limits high.** `up_s` and `dn_s` high together in any state moves to FAULT. This takes priority over all other transitions.
- **One pulse per grant.** The `passed` flag guarantees at most one `car_entered` or `car_abort` per grant, including across obstruction reversals.
- **`car_entered` and `car_abort` are mutually exclusive.** Both are registered.
- **Reset mid-operation.** `reset_n` low in any state forces all outputs to 0 immediately and returns the FSM to CLOSED. No pulse is emitted, and the barrier position is not remembered.

## Timing
- `access_granted` high before edge N: at edge N the state becomes OPENING. `motor_up` = 1 and `busy` = 1 are visible after edge N.
- An asynchronous sensor change sampled at edge N appears on its synced signal after edge N+1. The FSM reacts at edge N+2, so there are 3 edges of latency to an output change.
- `car_entered` and `car_abort` are high for exactly one cycle, in the first cycle of CLOSING.
- Timeouts are measured in cycles spent in the state, starting at 0 on entry. For example, FAULT from OPENING is entered on the edge after the counter reads `TRAVEL_MAX`.
- `motor_up` and `motor_down` are never high in the same cycle.

## Structure
- Package `gate_pkg`:
  - state enum: CLOSED, OPENING, OPEN_WAIT, CAR_IN, CLOSING, FAULT;
  - default parameter constants;
  - a counter-width function.
- Sub-module `gate_sync`: a parameterized-width 2-flop synchronizer with async active-low reset to 0. It is instantiated once, 3 bits wide.
- Top: FSM, shared counter, `passed` flag, registered output decode.

## Test plan
Bench parameters: `TRAVEL_MAX` = 20, `PASS_TIMEOUT` = 50, `CLEAR_HOLD` = 4.
- **Normal entry.** Grant pulse; raise `up_limit` after 10 cycles; loop high for 15 cycles, then low; raise `down_limit` 10 cycles later. Expect `motor_up` → 0 once up is seen, one `car_entered` pulse, CLOSED, `busy` = 0.
- **No car.** Grant; `up_limit` after 5 cycles; loop stays 0. Expect one `car_abort` 50 cycles after OPEN_WAIT entry, then `motor_down` = 1 and no `car_entered`.
- **Obstruction.** During CLOSING, assert loop for 3 cycles. Expect `motor_down` → 0 and `motor_up` → 1 within 3 edges, then a normal reclose. Across the whole sequence expect exactly one `car_entered`.
- **Motor stall.** Grant; never assert `up_limit`. Expect `gate_fault` = 1 and motors 0 after 20 OPENING cycles. A further grant is ignored until `reset_n` pulses.
- **Invalid limits and grant while busy.** Both limits high while OPEN_WAIT: expect FAULT. Separately, a second grant during CAR_IN: expect no effect.
- **Reset mid-operation.** Drop `reset_n` during OPENING. Expect `motor_up`, `busy` and `gate_fault` all 0 immediately, with no pulse on `car_entered` or `car_abort`.
